// File: rtl/cyclic_lamp.sv
// Three-lamp cyclic sequencer RED -> GREEN -> YELLOW with per-state dwell.
// Optional pause input is enabled by defining CYCLIC_LAMP_PAUSE_EN.
module cyclic_lamp #(
  parameter int RED_CYCLES    = 1,
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CYCLIC_LAMP_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] light
);

  localparam logic [1:0] S_RED    = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  localparam logic [15:0] RED_LAST = 16'(RED_CYCLES - 1);
  localparam logic [15:0] GRN_LAST = 16'(GREEN_CYCLES - 1);
  localparam logic [15:0] YEL_LAST = 16'(YELLOW_CYCLES - 1);

  if (RED_CYCLES < 1 || RED_CYCLES > 65535) begin : g_bad_red
    $error("cyclic_lamp: RED_CYCLES out of range 1..65535");
  end
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 65535) begin : g_bad_grn
    $error("cyclic_lamp: GREEN_CYCLES out of range 1..65535");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 65535) begin : g_bad_yel
    $error("cyclic_lamp: YELLOW_CYCLES out of range 1..65535");
  end

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic        w_pause;
  logic        w_legal;
  logic        w_last;
  logic [1:0]  w_next;
  logic [2:0]  w_next_light;

`ifdef CYCLIC_LAMP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  always_comb begin
    w_legal      = 1'b1;
    w_last       = 1'b0;
    w_next       = S_RED;
    w_next_light = 3'b100;
    case (r_state)
      S_RED: begin
        w_last       = (r_cnt == RED_LAST);
        w_next       = S_GREEN;
        w_next_light = 3'b010;
      end
      S_GREEN: begin
        w_last       = (r_cnt == GRN_LAST);
        w_next       = S_YELLOW;
        w_next_light = 3'b001;
      end
      S_YELLOW: begin
        w_last       = (r_cnt == YEL_LAST);
        w_next       = S_RED;
        w_next_light = 3'b100;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal encodings recover ahead of pause so a frozen FSM cannot stay corrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RED;
      r_cnt   <= '0;
      light   <= 3'b100;
    end else if (!w_legal) begin
      r_state <= S_RED;
      r_cnt   <= '0;
      light   <= 3'b100;
    end else if (w_pause) begin
      r_state <= r_state;
      r_cnt   <= r_cnt;
    end else if (w_last) begin
      r_state <= w_next;
      r_cnt   <= '0;
      light   <= w_next_light;
    end else begin
      r_cnt   <= r_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cyclic_lamp.sv
// Scoreboard bench for cyclic_lamp: default and 3/2/1 dwell instances,
// plus a RED=4 pause instance when CYCLIC_LAMP_PAUSE_EN is defined.
module tb_cyclic_lamp;

`ifdef CYCLIC_LAMP_PAUSE_EN
  localparam int NDUT = 3;
`else
  localparam int NDUT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_pause = 1'b0;
  logic       chk_en = 1'b0;
  logic [2:0] l0, l1, l2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         id;
    logic [2:0] exp;
  } sb_t;

  sb_t sb_q[$];

  int midx[3];
  int mcnt[3];
  int dw[3][3] = '{'{1, 1, 1}, '{3, 2, 1}, '{4, 2, 2}};
  logic [2:0] lut[3] = '{3'b100, 3'b010, 3'b001};

  always #5 clk = ~clk;

  cyclic_lamp u0 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CYCLIC_LAMP_PAUSE_EN
    .pause(1'b0),
`endif
    .light(l0)
  );

  cyclic_lamp #(
    .RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CYCLIC_LAMP_PAUSE_EN
    .pause(1'b0),
`endif
    .light(l1)
  );

`ifdef CYCLIC_LAMP_PAUSE_EN
  cyclic_lamp #(
    .RED_CYCLES(4), .GREEN_CYCLES(2), .YELLOW_CYCLES(2)
  ) u2 (
    .clk(clk),
    .rst_n(rst_n),
    .pause(tb_pause),
    .light(l2)
  );
`else
  assign l2 = 3'b100;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] obs_light(input int id);
    case (id)
      0:       return l0;
      1:       return l1;
      default: return l2;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("onehot_u0", {31'd0, $onehot(l0)}, 32'd1);
      check("onehot_u1", {31'd0, $onehot(l1)}, 32'd1);
      check("onehot_u2", {31'd0, $onehot(l2)}, 32'd1);
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      midx[d] = 0;
      mcnt[d] = 0;
    end
  endtask

  task automatic step();
    sb_t e;
    logic pz;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      pz = (d == 2) ? tb_pause : 1'b0;
      if (!pz) begin
        if (mcnt[d] == dw[d][midx[d]] - 1) begin
          midx[d] = (midx[d] + 1) % 3;
          mcnt[d] = 0;
        end else begin
          mcnt[d]++;
        end
      end
      e.id  = d;
      e.exp = lut[midx[d]];
      sb_q.push_back(e);
    end
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("light_u%0d", e.id), 32'(obs_light(e.id)), 32'(e.exp));
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_u0", 32'(l0), 32'h4);
    check("rst_u1", 32'(l1), 32'h4);
    check("rst_u2", 32'(l2), 32'h4);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_to_u1_green(input string tag);
    for (int k = 0; k < 20 && midx[1] != 1; k++) step();
    check(tag, 32'(l1), 32'h2);
  endtask

  initial begin
    model_reset();
    reset_seq();
    chk_en = 1'b1;
    repeat (100) step();

    run_to_u1_green("reach_green_a");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_u0", 32'(l0), 32'h4);
    check("async_rst_u1", 32'(l1), 32'h4);
    check("async_rst_u2", 32'(l2), 32'h4);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (14) step();

`ifdef CYCLIC_LAMP_PAUSE_EN
    reset_seq();
    repeat (2) step();
    tb_pause = 1'b1;
    repeat (5) step();
    tb_pause = 1'b0;
    repeat (3) step();
    check("pause_to_green", 32'(l2), 32'h2);
    repeat (10) step();
`endif

    run_to_u1_green("reach_green_b");
    force u1.r_state = 2'b11;
    @(posedge clk);
    #1;
    check("illegal_light", 32'(l1), 32'h4);
    check("illegal_cnt", 32'(u1.r_cnt), 32'h0);
    release u1.r_state;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
